// File: rtl/hevc_filter_pkg.sv
// Shared types, token widths and block-size helpers for the HEVC filter job sequencer.
package hevc_filter_pkg;

  localparam int unsigned TAP         = 8;
  localparam int unsigned ALPHA_TOK_W = 4;
  localparam int unsigned SIZE_TOK_W  = 8;
  localparam int unsigned CNT_W       = 13;

  typedef enum logic [2:0] {
    S4  = 3'd0,
    S8  = 3'd1,
    S16 = 3'd2,
    S32 = 3'd3,
    S64 = 3'd4
  } size_code_t;

  typedef enum logic [2:0] {
    StIdle,
    StCfg,
    StFeed,
    StDrain,
    StDone
  } state_t;

  function automatic logic size_legal(input logic [2:0] code);
    return code <= 3'd4;
  endfunction

  function automatic logic [6:0] blk_edge(input size_code_t code);
    return 7'd4 << code;
  endfunction

  function automatic logic [6:0] ext_size(input size_code_t code, input int unsigned tap);
    return blk_edge(code) + 7'(tap - 1);
  endfunction

  function automatic logic [CNT_W-1:0] blk_pels(input size_code_t code);
    logic [6:0] e;
    e = blk_edge(code);
    return CNT_W'(e) * CNT_W'(e);
  endfunction

endpackage

// File: rtl/hevc_filter_seq_cfg_token_writer.sv
// Holds one configuration token and keeps its write asserted until the FIFO takes it.
module cfg_token_writer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] token,
  input  logic         full,
  output logic         write,
  output logic [W-1:0] din,
  output logic         accept
);

  logic         write_q;
  logic [W-1:0] din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      din_q   <= '0;
    end else if (load) begin
      write_q <= 1'b1;
      din_q   <= token;
    end else if (write_q && !full) begin
      write_q <= 1'b0;
    end
  end

  assign write  = write_q;
  assign din    = din_q;
  assign accept = write_q & ~full;

endmodule

// File: rtl/hevc_filter_seq.sv
// Job sequencer for top_ms: issues config tokens, streams reference pels, counts filtered outputs.
module hevc_filter_seq #(
  parameter int unsigned TAP   = 8,
  parameter int unsigned PEL_W = 8,
  parameter int unsigned FLUX  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [2:0]       job_size,
  input  logic [2:0]       job_v_alpha,
  input  logic [2:0]       job_h_alpha,
  output logic [3:0]       cfg_v_din,
  output logic [3:0]       cfg_h_din,
  output logic [7:0]       cfg_s_din,
  output logic             cfg_v_write,
  output logic             cfg_h_write,
  output logic             cfg_s_write,
  input  logic             cfg_v_full,
  input  logic             cfg_h_full,
  input  logic             cfg_s_full,
  input  logic             src_valid,
  input  logic [PEL_W-1:0] src_data,
  output logic             src_ready,
  output logic [PEL_W:0]   pel_din,
  output logic             pel_write,
  input  logic             pel_full,
  input  logic             out_write,
  input  logic             out_full,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import hevc_filter_pkg::*;

  if (FLUX == 0) begin : g_flux_invalid
    $error("FLUX must be nonzero");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_in_q, n_out_q;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             err_q, err_d;
  logic             load;
  logic             pel_xfer;
  logic             out_acc;
  logic             counting;
  logic             all_acc;
  logic             v_acc, h_acc, s_acc;
  size_code_t       code_in;
  logic [6:0]       ext_in;

  assign code_in  = size_code_t'(job_size);
  assign ext_in   = ext_size(code_in, TAP);
  assign pel_xfer = (state_q == StFeed) & src_valid & ~pel_full;
  assign out_acc  = out_write & ~out_full;
  assign counting = (state_q == StCfg) | (state_q == StFeed) | (state_q == StDrain);
  // A token still pending this cycle must be accepted now for the CFG phase to finish.
  assign all_acc  = (~cfg_v_write | v_acc) & (~cfg_h_write | h_acc) & (~cfg_s_write | s_acc);

  cfg_token_writer #(.W(ALPHA_TOK_W)) u_cfg_v (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .token  ({1'b1, job_v_alpha}),
    .full   (cfg_v_full),
    .write  (cfg_v_write),
    .din    (cfg_v_din),
    .accept (v_acc)
  );

  cfg_token_writer #(.W(ALPHA_TOK_W)) u_cfg_h (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .token  ({1'b1, job_h_alpha}),
    .full   (cfg_h_full),
    .write  (cfg_h_write),
    .din    (cfg_h_din),
    .accept (h_acc)
  );

  cfg_token_writer #(.W(SIZE_TOK_W)) u_cfg_s (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .token  ({1'b1, ext_in}),
    .full   (cfg_s_full),
    .write  (cfg_s_write),
    .din    (cfg_s_din),
    .accept (s_acc)
  );

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;
    load      = 1'b0;

    // Outputs may overlap feeding; any output outside a job or beyond the block is an error.
    if (out_acc) begin
      if (!counting || out_cnt_q == n_out_q) begin
        err_d = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (job_valid) begin
          if (size_legal(job_size)) begin
            load    = 1'b1;
            state_d = StCfg;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StCfg: begin
        if (all_acc) state_d = StFeed;
      end
      StFeed: begin
        if (pel_xfer) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_cnt_q + CNT_W'(1) == n_in_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_cnt_q == n_out_q) state_d = StDone;
      end
      StDone: begin
        state_d   = StIdle;
        in_cnt_d  = '0;
        out_cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
      n_in_q    <= '0;
      n_out_q   <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
      if (load) begin
        n_in_q  <= CNT_W'(ext_in) * CNT_W'(ext_in);
        n_out_q <= blk_pels(code_in);
      end
    end
  end

  assign job_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign pel_write = pel_xfer;
  assign src_ready = pel_xfer;
  assign pel_din   = (state_q == StFeed) ? {1'b1, src_data} : '0;

endmodule

// File: tb/tb_hevc_filter_seq.sv
// Directed bench for hevc_filter_seq: the bench plays host, source and filter output port.
module tb_hevc_filter_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       job_valid;
  logic       job_ready;
  logic [2:0] job_size, job_v_alpha, job_h_alpha;
  logic [3:0] cfg_v_din, cfg_h_din;
  logic [7:0] cfg_s_din;
  logic       cfg_v_write, cfg_h_write, cfg_s_write;
  logic       cfg_v_full, cfg_h_full, cfg_s_full;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic [8:0] pel_din;
  logic       pel_write, pel_full;
  logic       out_write, out_full;
  logic       busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  int r_pels, r_outs, r_bad, r_din_bad, r_vw, r_hw, r_sw, r_first, r_done, r_done_outs, r_busy_bad;
  logic [3:0] tok_v, tok_h;
  logic [7:0] tok_s;

  always #5 clk = ~clk;

  hevc_filter_seq #(.TAP(8), .PEL_W(8), .FLUX(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_size    (job_size),
    .job_v_alpha (job_v_alpha),
    .job_h_alpha (job_h_alpha),
    .cfg_v_din   (cfg_v_din),
    .cfg_h_din   (cfg_h_din),
    .cfg_s_din   (cfg_s_din),
    .cfg_v_write (cfg_v_write),
    .cfg_h_write (cfg_h_write),
    .cfg_s_write (cfg_s_write),
    .cfg_v_full  (cfg_v_full),
    .cfg_h_full  (cfg_h_full),
    .cfg_s_full  (cfg_s_full),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .pel_din     (pel_din),
    .pel_write   (pel_write),
    .pel_full    (pel_full),
    .out_write   (out_write),
    .out_full    (out_full),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " job_ready"}, 32'(job_ready), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " cfg writes"}, 32'({cfg_v_write, cfg_h_write, cfg_s_write}), 32'd0);
    check({tag, " cfg dins"}, 32'({cfg_v_din, cfg_h_din, cfg_s_din}), 32'd0);
    check({tag, " pel_write/src_ready"}, 32'({pel_write, src_ready}), 32'd0);
    check({tag, " pel_din"}, 32'(pel_din), 32'd0);
  endtask

  // Plays one job: the model filter emits one output per cycle once half the pels are in.
  task automatic run_job(input logic [2:0] code, input logic [2:0] va, input logic [2:0] ha,
                         input bit rnd, input int s_full_n, input int abort_at);
    int e, ni, no;
    e  = (4 << code) + 7;
    ni = e * e;
    no = (4 << code) * (4 << code);
    r_pels = 0; r_outs = 0; r_bad = 0; r_din_bad = 0; r_vw = 0; r_hw = 0; r_sw = 0;
    r_first = 0; r_done = 0; r_done_outs = -1; r_busy_bad = 0;
    job_valid = 1'b1; job_size = code; job_v_alpha = va; job_h_alpha = ha;
    @(posedge clk); @(negedge clk);
    job_valid = 1'b0;
    for (int c = 1; c <= 12000; c++) begin
      src_valid  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      pel_full   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      src_data   = 8'($urandom);
      cfg_s_full = (c <= s_full_n);
      out_write  = (r_outs < no) && (r_pels >= ni / 2);
      out_full   = 1'b0;
      #1;
      if (c == 1) begin
        tok_v = cfg_v_din; tok_h = cfg_h_din; tok_s = cfg_s_din;
      end
      if (cfg_v_write) r_vw++;
      if (cfg_h_write) r_hw++;
      if (cfg_s_write) r_sw++;
      if (src_ready !== pel_write) r_bad++;
      if (pel_write) begin
        if (pel_full || !src_valid) r_bad++;
        if (pel_din !== {1'b1, src_data}) r_din_bad++;
        if (r_first == 0) r_first = c;
        r_pels++;
      end
      if (out_write && !out_full) r_outs++;
      if (!busy) r_busy_bad++;
      if (done) begin
        r_done = 1; r_done_outs = r_outs;
        break;
      end
      if (abort_at != 0 && r_pels == abort_at) break;
      @(posedge clk); @(negedge clk);
    end
    src_valid = 1'b0; out_write = 1'b0; cfg_s_full = 1'b0; pel_full = 1'b0;
  endtask

  task automatic check_job(input string tag, input int pels, input int outs);
    check({tag, " done seen"}, 32'(r_done), 32'd1);
    check({tag, " pel writes"}, 32'(r_pels), 32'(pels));
    check({tag, " outputs at done"}, 32'(r_done_outs), 32'(outs));
    check({tag, " illegal pel writes"}, 32'(r_bad), 32'd0);
    check({tag, " pel_din errors"}, 32'(r_din_bad), 32'd0);
    check({tag, " busy drops"}, 32'(r_busy_bad), 32'd0);
  endtask

  task automatic after_done(input string tag);
    @(posedge clk); @(negedge clk); #1;
    check({tag, " job_ready after done"}, 32'(job_ready), 32'd1);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    job_valid = 1'b0; job_size = '0; job_v_alpha = '0; job_h_alpha = '0;
    cfg_v_full = 1'b0; cfg_h_full = 1'b0; cfg_s_full = 1'b0;
    src_valid = 1'b0; src_data = '0; pel_full = 1'b0; out_write = 1'b0; out_full = 1'b0;
    #1;
    check_idle_outputs("reset");
    check("reset err", 32'(err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Nominal 16x16 job, phases 2/2.
    run_job(3'd2, 3'd2, 3'd2, 1'b0, 0, 0);
    check("j16 tok v", 32'(tok_v), 32'hA);
    check("j16 tok h", 32'(tok_h), 32'hA);
    check("j16 tok s", 32'(tok_s), 32'h97);
    check("j16 cfg write cycles", 32'({8'(r_vw), 8'(r_hw), 8'(r_sw)}), 32'h010101);
    check("j16 first pel cycle", 32'(r_first), 32'd2);
    check_job("j16", 529, 256);
    check("j16 err", 32'(err), 32'd0);
    after_done("j16");

    // Size token held off for 5 cycles.
    run_job(3'd0, 3'd5, 3'd1, 1'b0, 5, 0);
    check("sfull v write cycles", 32'(r_vw), 32'd1);
    check("sfull h write cycles", 32'(r_hw), 32'd1);
    check("sfull s write cycles", 32'(r_sw), 32'd6);
    check("sfull first pel cycle", 32'(r_first), 32'd7);
    check("sfull tok v", 32'(tok_v), 32'hD);
    check("sfull tok s", 32'(tok_s), 32'h8B);
    check_job("sfull", 121, 16);
    after_done("sfull");

    // Random backpressure and source gaps.
    run_job(3'd0, 3'd7, 3'd0, 1'b1, 0, 0);
    check_job("rnd4", 121, 16);
    check("rnd4 err", 32'(err), 32'd0);
    after_done("rnd4");

    // Illegal size code is dropped and flags an error.
    job_valid = 1'b1; job_size = 3'd6;
    @(posedge clk); @(negedge clk);
    job_valid = 1'b0;
    #1;
    check("illegal err", 32'(err), 32'd1);
    check("illegal busy", 32'(busy), 32'd0);
    check("illegal cfg writes", 32'({cfg_v_write, cfg_h_write, cfg_s_write}), 32'd0);
    @(posedge clk); @(negedge clk); #1;
    check("illegal busy later", 32'(busy), 32'd0);
    run_job(3'd0, 3'd3, 3'd3, 1'b0, 0, 0);
    check_job("after illegal", 121, 16);
    after_done("after illegal");

    // Asynchronous reset in the middle of feeding.
    run_job(3'd2, 3'd1, 3'd4, 1'b0, 0, 300);
    check("abort reached pel 300", 32'(r_pels), 32'd300);
    src_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    check("midrst err cleared", 32'(err), 32'd0);
    src_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_job(3'd2, 3'd0, 3'd6, 1'b0, 0, 0);
    check_job("post rst", 529, 256);
    after_done("post rst");

    // Back-to-back jobs of code 1 then code 4.
    run_job(3'd1, 3'd4, 3'd5, 1'b0, 0, 0);
    check_job("b2b8", 225, 64);
    after_done("b2b8");
    run_job(3'd4, 3'd6, 3'd2, 1'b0, 0, 0);
    check("b2b64 tok s", 32'(tok_s), 32'hC7);
    check("b2b64 first pel cycle", 32'(r_first), 32'd2);
    check_job("b2b64", 5041, 4096);
    check("b2b64 err", 32'(err), 32'd0);
    after_done("b2b64");

    // Output handshake while idle is an error.
    out_write = 1'b1;
    @(posedge clk); @(negedge clk);
    out_write = 1'b0;
    #1;
    check("idle output err", 32'(err), 32'd1);
    check("idle output busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
